// File: rtl/guess_round_controller.sv
// rtl/guess_round_controller.sv - round sequencer for the 4-digit ?A?B guess-number game
//
// Collects four validated digits into a guess, hands it to the scorer over a
// req/ack handshake, counts attempts and selects the display source.
// Optional feature: define GUESS_DUP_CHECK_EN to reject digits already in the guess.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   start_pulse             start / restart a game
//   check_pulse             append a digit, submit a guess or dismiss the result
//   digit_in, digit_valid   current digit and its legality (0..9)
//   score_ack               scorer result valid (level)
//   a_count, b_count        bulls / cows from the scorer
//   secret_load             one-cycle pulse to latch a new secret
//   score_req               guess is stable and must be scored
//   guess, digit_count      entered BCD digits ([15:12] oldest) and their count
//   reject                  one-cycle pulse when a check is refused
//   a_result, b_result      A/B captured at the last ack
//   tries_used              completed attempts this game
//   disp_sel                0 entry, 1 ?A?B, 2 win, 3 lose
//   win, lose               end-of-game levels
module guess_round_controller #(
  parameter int MAX_TRIES   = 8,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_pulse,
  input  logic        check_pulse,
  input  logic [3:0]  digit_in,
  input  logic        digit_valid,
  input  logic        score_ack,
  input  logic [2:0]  a_count,
  input  logic [2:0]  b_count,
  output logic        secret_load,
  output logic        score_req,
  output logic [15:0] guess,
  output logic [2:0]  digit_count,
  output logic        reject,
  output logic [2:0]  a_result,
  output logic [2:0]  b_result,
  output logic [3:0]  tries_used,
  output logic [1:0]  disp_sel,
  output logic        win,
  output logic        lose
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [3:0]    TRY_LIMIT = 4'(MAX_TRIES);

  typedef enum logic [2:0] {
    IDLE, ENTRY, SCORE_WAIT, SHOW_AB, WIN, LOSE
  } state_t;

  state_t state_q, state_d;

  logic [HW-1:0] hold_q, hold_d;
  logic [15:0]   guess_d;
  logic [2:0]    digit_count_d, a_result_d, b_result_d;
  logic [3:0]    tries_d, tries_next;
  logic          score_req_d, secret_load_d, reject_d, dup;
  logic [1:0]    disp_sel_d;

  // Newest digit sits in guess[3:0], so the digits entered so far occupy the
  // lowest digit_count nibbles.
  always_comb begin
    dup = 1'b0;
`ifdef GUESS_DUP_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < digit_count && guess[i*4 +: 4] == digit_in) dup = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    guess_d       = guess;
    digit_count_d = digit_count;
    a_result_d    = a_result;
    b_result_d    = b_result;
    tries_d       = tries_used;
    score_req_d   = score_req;
    secret_load_d = 1'b0;
    reject_d      = 1'b0;
    tries_next    = tries_used + 4'd1;

    // The handshake is never abandoned, so start is deaf in SCORE_WAIT.
    if (start_pulse && state_q != SCORE_WAIT) begin
      state_d       = ENTRY;
      secret_load_d = 1'b1;
      guess_d       = '0;
      digit_count_d = '0;
      tries_d       = '0;
      a_result_d    = '0;
      b_result_d    = '0;
      score_req_d   = 1'b0;
    end else begin
      case (state_q)
        ENTRY: begin
          if (check_pulse) begin
            if (digit_count == 3'd4) begin
              state_d     = SCORE_WAIT;
              score_req_d = 1'b1;
            end else if (digit_valid && !dup) begin
              guess_d       = {guess[11:0], digit_in};
              digit_count_d = digit_count + 3'd1;
            end else begin
              reject_d = 1'b1;
            end
          end
        end
        SCORE_WAIT: begin
          if (score_ack) begin
            a_result_d  = a_count;
            b_result_d  = b_count;
            tries_d     = tries_next;
            score_req_d = 1'b0;
            if (a_count == 3'd4) begin
              state_d = WIN;
            end else if (tries_next == TRY_LIMIT) begin
              state_d = LOSE;
            end else begin
              state_d = SHOW_AB;
              hold_d  = HOLD_LOAD;
            end
          end
        end
        SHOW_AB: begin
          if (hold_q == '0 || check_pulse) begin
            state_d       = ENTRY;
            guess_d       = '0;
            digit_count_d = '0;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
        default: ;
      endcase
    end

    case (state_d)
      SHOW_AB: disp_sel_d = 2'd1;
      WIN:     disp_sel_d = 2'd2;
      LOSE:    disp_sel_d = 2'd3;
      default: disp_sel_d = 2'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      guess       <= '0;
      digit_count <= '0;
      a_result    <= '0;
      b_result    <= '0;
      tries_used  <= '0;
      score_req   <= 1'b0;
      secret_load <= 1'b0;
      reject      <= 1'b0;
      disp_sel    <= 2'd0;
      win         <= 1'b0;
      lose        <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      guess       <= guess_d;
      digit_count <= digit_count_d;
      a_result    <= a_result_d;
      b_result    <= b_result_d;
      tries_used  <= tries_d;
      score_req   <= score_req_d;
      secret_load <= secret_load_d;
      reject      <= reject_d;
      disp_sel    <= disp_sel_d;
      win         <= (state_d == WIN);
      lose        <= (state_d == LOSE);
    end
  end

endmodule

// File: tb/tb_guess_round_controller.sv
// tb/tb_guess_round_controller.sv - directed self-checking bench for guess_round_controller
module tb_guess_round_controller;

  logic        clock = 1'b0;
  logic        reset, start_pulse, check_pulse, digit_valid, score_ack;
  logic [3:0]  digit_in;
  logic [2:0]  a_count, b_count;
  logic        secret_load, score_req, reject, win, lose;
  logic [15:0] guess;
  logic [2:0]  digit_count, a_result, b_result;
  logic [3:0]  tries_used;
  logic [1:0]  disp_sel;

  int vectors = 0;
  int miscompares = 0;

  guess_round_controller #(.MAX_TRIES(2), .HOLD_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .start_pulse(start_pulse), .check_pulse(check_pulse),
    .digit_in(digit_in), .digit_valid(digit_valid), .score_ack(score_ack),
    .a_count(a_count), .b_count(b_count), .secret_load(secret_load), .score_req(score_req),
    .guess(guess), .digit_count(digit_count), .reject(reject), .a_result(a_result),
    .b_result(b_result), .tries_used(tries_used), .disp_sel(disp_sel), .win(win), .lose(lose)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic press(input int d, input logic v);
    digit_in    = 4'(d);
    digit_valid = v;
    check_pulse = 1'b1;
    tick();
    check_pulse = 1'b0;
  endtask

  task automatic ack(input int a, input int b);
    a_count   = 3'(a);
    b_count   = 3'(b);
    score_ack = 1'b1;
    tick();
    score_ack = 1'b0;
  endtask

  task automatic start_game();
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_pulse = 1'b0; check_pulse = 1'b0; digit_valid = 1'b0;
    score_ack = 1'b0; digit_in = 4'd0; a_count = 3'd0; b_count = 3'd0;
    tick(); tick();
    check("rst_guess", guess, 16'h0);
    check("rst_count", 16'(digit_count), 16'd0);
    check("rst_tries", 16'(tries_used), 16'd0);
    check("rst_flags", {10'b0, score_req, secret_load, reject, win, lose, 1'b0}, 16'h0);
    check("rst_disp", 16'(disp_sel), 16'd0);
    reset = 1'b0;

    press(3, 1'b1);
    check("idle_ignores_check", 16'(digit_count), 16'd0);

    start_game();
    check("start_secret_load", 16'(secret_load), 16'd1);
    check("start_guess", guess, 16'h0);
    tick();
    check("secret_load_width", 16'(secret_load), 16'd0);

    press(1, 1'b1);
    check("first_digit", {guess[11:0], 1'b0, digit_count}, {12'h001, 4'd1});
    press(2, 1'b1); press(3, 1'b1); press(4, 1'b1);
    check("four_digits", guess, 16'h1234);
    check("four_count", 16'(digit_count), 16'd4);
    press(9, 1'b0);
    check("submit_req", 16'(score_req), 16'd1);
    check("submit_no_reject", 16'(reject), 16'd0);
    tick();
    check("req_held", {15'b0, score_req}, 16'd1);
    ack(1, 2);
    check("ack_results", {7'b0, a_result, 3'b0, b_result}, {7'b0, 3'd1, 3'b0, 3'd2});
    check("ack_tries", 16'(tries_used), 16'd1);
    check("ack_req_low", 16'(score_req), 16'd0);
    check("show_disp", 16'(disp_sel), 16'd1);
    tick(); tick(); tick();
    check("hold_last_cycle", 16'(disp_sel), 16'd1);
    tick();
    check("hold_done_disp", 16'(disp_sel), 16'd0);
    check("hold_done_guess", guess, 16'h0);
    check("hold_keep_tries", 16'(tries_used), 16'd1);

    press(5, 1'b1); press(6, 1'b1); press(7, 1'b1); press(8, 1'b1);
    press(0, 1'b1);
    ack(4, 0);
    check("win_flag", {14'b0, win, lose}, 16'b10);
    check("win_disp", 16'(disp_sel), 16'd2);
    check("win_result", 16'(a_result), 16'd4);

    start_game();
    check("restart_tries", 16'(tries_used), 16'd0);
    check("restart_state", {12'b0, win, disp_sel, secret_load}, 16'b0001);

    press(1, 1'b1); press(2, 1'b1); press(3, 1'b1); press(4, 1'b1);
    press(0, 1'b1);
    ack(0, 5);
    check("b_over_four", 16'(b_result), 16'd5);
    check("show_again", 16'(disp_sel), 16'd1);
    press(0, 1'b1);
    check("early_dismiss", {13'b0, digit_count}, 16'd0);
    check("early_dismiss_disp", 16'(disp_sel), 16'd0);

    press(9, 1'b0);
    check("invalid_reject", {12'b0, reject, digit_count}, {12'b0, 1'b1, 3'd0});
    tick();
    check("reject_width", 16'(reject), 16'd0);
    press(7, 1'b1);
    press(7, 1'b1);
`ifdef GUESS_DUP_CHECK_EN
    check("dup_reject", {12'b0, reject, digit_count}, {12'b0, 1'b1, 3'd1});
    press(1, 1'b1); press(2, 1'b1); press(3, 1'b1);
    check("guess_after_dup", guess, 16'h7123);
`else
    check("dup_accept", {12'b0, reject, digit_count}, {12'b0, 1'b0, 3'd2});
    press(1, 1'b1); press(2, 1'b1);
    check("guess_after_dup", guess, 16'h7712);
`endif
    press(0, 1'b1);
    ack(2, 1);
    check("lose_flag", {14'b0, win, lose}, 16'b01);
    check("lose_disp", 16'(disp_sel), 16'd3);
    check("lose_tries", 16'(tries_used), 16'd2);

    start_pulse = 1'b1;
    press(5, 1'b1);
    start_pulse = 1'b0;
    check("start_from_lose", {12'b0, lose, digit_count}, 16'd0);
    press(3, 1'b1);
    start_pulse = 1'b1;
    press(4, 1'b1);
    start_pulse = 1'b0;
    check("start_beats_check", {12'b0, secret_load, digit_count}, {12'b0, 1'b1, 3'd0});

    press(1, 1'b1); press(2, 1'b1); press(3, 1'b1); press(4, 1'b1);
    press(0, 1'b1);
    start_game();
    check("start_ignored_wait", {14'b0, score_req, secret_load}, 16'b10);
    check("guess_frozen", guess, 16'h1234);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_mid_req", 16'(score_req), 16'd0);
    check("reset_mid_state", {11'b0, disp_sel, digit_count}, 16'd0);
    press(6, 1'b1);
    check("reset_to_idle", 16'(digit_count), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
